fft_stage_scheduler: RTL

- Top-level sequencer for the in-place/ping-pong radix-2 FFT stage datapath.
- Accepts N input samples and drives the stage RAM load port with bit-reversed addresses.
- Launches log2(N) stages one at a time. Each stage completes only after the datapath's stage-done pulse and N write-back beats.
- Then streams N result addresses to the unload side under a valid/ready handshake.

---
 rtl/fft_sched_pkg.sv | 35 +++
 rtl/fft_stage_scheduler_if.sv | 39 +++
 rtl/fft_stage_watchdog.sv | 34 +++
 rtl/fft_stage_scheduler.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/fft_sched_pkg.sv
// Purpose : shared types, default sizing and helpers for the FFT stage scheduler.
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package fft_sched_pkg;

    // Scheduler sequence: load samples, run each stage (START/RUN pairs), then unload.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_START  = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4
    } state_e;

    localparam int DEF_N       = 16;
    localparam int DEF_SIZE    = $clog2(DEF_N);
    localparam int DEF_STAGE_W = $clog2(DEF_SIZE + 1);
    localparam int DEF_TIMEOUT = 1023;

    // Reverse the low w bits of v. Built from shifts so no variable bit index is needed.
    function automatic logic [31:0] bit_rev(input logic [31:0] v, input int w);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        t = v;
        for (int i = 0; i < 32; i++) begin
            if (i < w) begin
                r = {r[30:0], t[0]};
                t = {1'b0, t[31:1]};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_stage_scheduler_if.sv
// Purpose : bundles the scheduler's load, stage-control and unload signals.
// Latency : n/a (wiring only).
// Backpressure: in_ready on the load side, out_ready on the unload side.
// Ports   : master = scheduler side, slave = sample source / datapath / unload consumer.
interface fft_stage_scheduler_if
    import fft_sched_pkg::*;
#(
    parameter int SIZE    = DEF_SIZE,
    parameter int STAGE_W = DEF_STAGE_W
);
    logic               start_fft;
    logic               in_valid;
    logic               in_ready;
    logic               load_data;
    logic [SIZE-1:0]    invert_addr;
    logic               stage_start;
    logic [STAGE_W-1:0] stage_idx;
    logic               bank_sel;
    logic               stage_done;
    logic               wr_en;
    logic               out_valid;
    logic               out_ready;
    logic [SIZE-1:0]    out_addr;
    logic               busy;
    logic               done;
    logic               err_timeout;

    modport master (
        input  start_fft, in_valid, stage_done, wr_en, out_ready,
        output in_ready, load_data, invert_addr, stage_start, stage_idx, bank_sel,
               out_valid, out_addr, busy, done, err_timeout
    );

    modport slave (
        output start_fft, in_valid, stage_done, wr_en, out_ready,
        input  in_ready, load_data, invert_addr, stage_start, stage_idx, bank_sel,
               out_valid, out_addr, busy, done, err_timeout
    );
endinterface

// File: rtl/fft_stage_watchdog.sv
// Purpose : per-stage cycle counter; flags the cycle in which the count reaches TIMEOUT.
// Latency : o_tc is combinational from the count and i_en (same cycle).
// Backpressure: none; counts while enabled, saturates at TIMEOUT.
// Ports   : i_clk, i_rst_n (sync, active low), i_clr (zero count), i_en (count this cycle),
//           o_tc (this enabled cycle brings the count to TIMEOUT).
module fft_stage_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TC_PREV = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] TC_MAX  = CW'(TIMEOUT);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != TC_MAX)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The N-th enabled cycle after a clear is the one that reaches TIMEOUT.
    assign o_tc = i_en && (r_cnt == TC_PREV);

endmodule

// File: rtl/fft_stage_scheduler.sv
// Purpose : sequences load (bit-reversed addresses), log2(N) butterfly stages and natural-order unload.
// Latency : first stage_start 1 cycle after the N-th load beat; done 1 cycle after the last unload handshake.
// Backpressure: load stalls on in_valid=0; unload holds out_addr while out_ready=0; stages wait on stage_done + N wr_en.
// Ports   : i_clk, i_rst_n (sync, active low), io_bus (master side of fft_stage_scheduler_if).
module fft_stage_scheduler
    import fft_sched_pkg::*;
#(
    parameter int N         = DEF_N,
    parameter int SIZE      = DEF_SIZE,
    parameter int NUM_STAGE = DEF_SIZE,
    parameter int STAGE_W   = DEF_STAGE_W,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    fft_stage_scheduler_if.master io_bus
);
    localparam logic [SIZE-1:0]    CNT_LAST   = SIZE'(N - 1);
    localparam logic [SIZE:0]      WR_FULL    = (SIZE + 1)'(N);
    localparam logic [SIZE:0]      WR_PENULT  = (SIZE + 1)'(N - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_STAGE - 1);

    state_e             r_state;
    state_e             w_next_state;
    logic [SIZE-1:0]    r_cnt;
    logic [SIZE:0]      r_wr_cnt;
    logic               r_done_seen;
    logic [STAGE_W-1:0] r_stage_idx;
    logic               r_bank_sel;
    logic               r_err_timeout;
    logic               r_stage_start;
    logic               r_busy;
    logic               r_done;

    logic               w_in_ready;
    logic               w_load_data;
    logic               w_out_valid;
    logic [SIZE-1:0]    w_out_addr;
    logic [SIZE-1:0]    w_invert_addr;
    logic               w_unload_hs;
    logic               w_wr_full;
    logic               w_seen;
    logic               w_stage_complete;
    logic               w_last_stage;
    logic               w_wd_tc;

    fft_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (r_state == ST_START),
        .i_en    (r_state == ST_RUN),
        .o_tc    (w_wd_tc)
    );

    // Stage completion: the last write beat and stage_done may land in either order or together,
    // so both the registered and the current-cycle events count.
    always_comb begin
        w_unload_hs      = w_out_valid && io_bus.out_ready;
        w_wr_full        = (r_wr_cnt == WR_FULL) || (io_bus.wr_en && (r_wr_cnt == WR_PENULT));
        w_seen           = r_done_seen || io_bus.stage_done;
        w_stage_complete = (r_state == ST_RUN) && w_wr_full && w_seen;
        w_last_stage     = (r_stage_idx == STAGE_LAST);
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (io_bus.start_fft) w_next_state = ST_LOAD;
            ST_LOAD:   if (w_load_data && (r_cnt == CNT_LAST)) w_next_state = ST_START;
            ST_START:  w_next_state = ST_RUN;
            ST_RUN: begin
                // A stage finishing on its timeout cycle is treated as finished.
                if (w_stage_complete) begin
                    w_next_state = w_last_stage ? ST_UNLOAD : ST_START;
                end else if (w_wd_tc) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_UNLOAD: if (w_unload_hs && (r_cnt == CNT_LAST)) w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    // Output decodes (state/counter only, apart from the load strobe)
    always_comb begin
        w_in_ready    = (r_state == ST_LOAD);
        w_out_valid   = (r_state == ST_UNLOAD);
        w_load_data   = io_bus.in_valid && w_in_ready;
        w_invert_addr = w_in_ready ? SIZE'(bit_rev(32'(r_cnt), SIZE)) : '0;
        w_out_addr    = w_out_valid ? r_cnt : '0;
    end

    // Counters, stage bookkeeping and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt         <= '0;
            r_wr_cnt      <= '0;
            r_done_seen   <= 1'b0;
            r_stage_idx   <= '0;
            r_bank_sel    <= 1'b0;
            r_err_timeout <= 1'b0;
            r_stage_start <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_stage_start <= (w_next_state == ST_START);
            r_busy        <= (w_next_state != ST_IDLE);
            r_done        <= w_unload_hs && (r_cnt == CNT_LAST);

            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start_fft) begin
                        r_cnt         <= '0;
                        r_stage_idx   <= '0;
                        r_bank_sel    <= 1'b0;
                        r_err_timeout <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // N is a power of two, so the counter wraps to 0 on the last beat.
                    if (w_load_data) r_cnt <= r_cnt + SIZE'(1);
                end
                ST_START: begin
                    r_wr_cnt    <= '0;
                    r_done_seen <= 1'b0;
                end
                ST_RUN: begin
                    if (io_bus.wr_en && (r_wr_cnt != WR_FULL)) r_wr_cnt <= r_wr_cnt + (SIZE + 1)'(1);
                    if (io_bus.stage_done) r_done_seen <= 1'b1;
                    if (w_stage_complete) begin
                        if (!w_last_stage) begin
                            r_stage_idx <= r_stage_idx + STAGE_W'(1);
                            r_bank_sel  <= ~r_bank_sel;
                        end
                    end else if (w_wd_tc) begin
                        r_err_timeout <= 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (w_unload_hs) r_cnt <= r_cnt + SIZE'(1);
                end
                default: ;
            endcase
        end
    end

    assign io_bus.in_ready    = w_in_ready;
    assign io_bus.load_data   = w_load_data;
    assign io_bus.invert_addr = w_invert_addr;
    assign io_bus.stage_start = r_stage_start;
    assign io_bus.stage_idx   = r_stage_idx;
    assign io_bus.bank_sel    = r_bank_sel;
    assign io_bus.out_valid   = w_out_valid;
    assign io_bus.out_addr    = w_out_addr;
    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.err_timeout = r_err_timeout;

endmodule
